// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, one-deep outstanding request and epoch-tagged queue.
// Redirects flip the epoch so words fetched under the old epoch are squashed downstream.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = 32'hE320F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        branch_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);
    localparam int AW = $clog2(QDEPTH);
    localparam int OW = AW + 2;

    logic [31:0] r_pc;
    logic        r_epoch;
    logic        r_inflight;
    logic        r_req_epoch;
    logic [31:0] r_req_addr;
    logic [31:0] r_q_instr [QDEPTH];
    logic        r_q_epoch [QDEPTH];
    logic [31:0] r_q_pc    [QDEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_deq;
    logic          w_enq;
    logic [OW-1:0] w_occ;

    assign instr_valid = (r_count != '0);
    assign w_deq       = instr_valid & ~sel_stall;
    // Occupancy counts the outstanding response so a full queue can never be overrun.
    assign w_occ       = OW'(r_count) + OW'(r_inflight) - OW'(w_deq);
    assign imem_req    = ~rst & ~redirect_en & (w_occ < OW'(QDEPTH));
    assign imem_addr   = {r_pc[31:2], 2'b00};
    assign w_enq       = imem_rvalid & r_inflight & (r_req_epoch == r_epoch) & ~redirect_en;

    assign instr_out   = instr_valid ? r_q_instr[r_rd_ptr] : NOP_INSTR;
    assign branch_out  = instr_valid ? r_q_epoch[r_rd_ptr] : r_epoch;
    assign pc_out      = instr_valid ? r_q_pc[r_rd_ptr]    : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= {RESET_PC[31:2], 2'b00};
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
            r_req_epoch <= 1'b0;
            r_req_addr  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else if (redirect_en) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_epoch    <= ~r_epoch;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (imem_req) begin
                r_pc        <= r_pc + 32'd4;
                r_inflight  <= 1'b1;
                r_req_epoch <= r_epoch;
                r_req_addr  <= imem_addr;
            end else if (imem_rvalid) begin
                r_inflight <= 1'b0;
            end
            if (w_enq) begin
                r_q_instr[r_wr_ptr] <= imem_rdata;
                r_q_epoch[r_wr_ptr] <= r_req_epoch;
                r_q_pc[r_wr_ptr]    <= r_req_addr;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_enq |-> (r_count < (AW+1)'(QDEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of reset, streaming, stall, redirect and PC wrap.
// Memory answers one cycle after each request with addr ^ 32'hA5A5_0000.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel_stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic [31:0] instr_out;
    logic        branch_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    int          n_chk  = 0;
    int          n_fail = 0;

    localparam logic [31:0] NOP = 32'hE320F000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    fetch_unit dut (
        .clk(clk), .rst(rst), .sel_stall(sel_stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .branch_out(branch_out), .pc_out(pc_out), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= imem_addr ^ KEY;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic ep);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, instr_out, pc ^ KEY);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_epoch"}, 32'(branch_out), 32'(ep));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel_stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        tick; tick;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_epoch", 32'(branch_out), 32'd0);
        check("rst_pc", pc_out, 32'd0);
        rst = 1'b0; #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'd0);
        tick;
        check("c1_addr", imem_addr, 32'd4);
        check("c1_valid", 32'(instr_valid), 32'd0);
        tick;
        check("c2_addr", imem_addr, 32'd8);
        head("s0", 32'h0, 1'b0);
        tick; head("s1", 32'h4, 1'b0);
        tick; head("s2", 32'h8, 1'b0);
        sel_stall = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(imem_req), 32'd0);
            head("stall_hold", 32'h8, 1'b0);
            tick;
        end
        sel_stall = 1'b0; #1;
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h10);
        head("rel0", 32'h8, 1'b0);
        tick; head("rel1", 32'hC, 1'b0);
        tick; head("rel2", 32'h10, 1'b0);
        redirect_en = 1'b1; redirect_pc = 32'h100; #1;
        check("rd1_req", 32'(imem_req), 32'd0);
        tick;
        redirect_en = 1'b0; #1;
        check("rd1_valid", 32'(instr_valid), 32'd0);
        check("rd1_epoch", 32'(branch_out), 32'd1);
        check("rd1_pcout", pc_out, 32'h100);
        check("rd1_addr", imem_addr, 32'h100);
        tick;
        check("rd1_drop", 32'(instr_valid), 32'd0);
        tick; head("rd1_first", 32'h100, 1'b1);
        sel_stall = 1'b1;
        tick; tick;
        check("full_req", 32'(imem_req), 32'd0);
        head("full_head", 32'h100, 1'b1);
        redirect_en = 1'b1; redirect_pc = 32'h203; #1;
        check("rd2_req", 32'(imem_req), 32'd0);
        tick;
        redirect_en = 1'b0; #1;
        check("rd2_valid", 32'(instr_valid), 32'd0);
        check("rd2_epoch", 32'(branch_out), 32'd0);
        check("rd2_addr", imem_addr, 32'h200);
        check("rd2_req1", 32'(imem_req), 32'd1);
        tick;
        check("rd2_drop", 32'(instr_valid), 32'd0);
        tick; head("rd2_first", 32'h200, 1'b0);
        sel_stall = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect_pc = 32'h80; #1;
        check("rd3_req", 32'(imem_req), 32'd0);
        check("rd3_valid", 32'(instr_valid), 32'd0);
        tick;
        redirect_en = 1'b0; #1;
        check("rd4_epoch", 32'(branch_out), 32'd0);
        check("rd4_addr", imem_addr, 32'h80);
        tick;
        check("rd4_drop", 32'(instr_valid), 32'd0);
        tick; head("rd4_first", 32'h80, 1'b0);
        tick; head("rd4_second", 32'h84, 1'b0);
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect_en = 1'b0; #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick;
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_req", 32'(imem_req), 32'd1);
        tick; head("wrap0", 32'hFFFF_FFFC, 1'b1);
        tick; head("wrap1", 32'h0, 1'b1);
        rst = 1'b1; #1;
        check("mrst_req", 32'(imem_req), 32'd0);
        tick;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_pc", pc_out, 32'd0);
        check("mrst_epoch", 32'(branch_out), 32'd0);
        check("mrst_instr", instr_out, NOP);
        tick;
        check("mrst_ignore", 32'(instr_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
